// File: rtl/cdb_select_scheduler_pkg.sv
// Shared definitions for the CDB select scheduler: bus count, idle select
// address, the per-bus select array type and a small wrap-increment helper.
package cdb_select_scheduler_pkg;

    localparam int CDB_BUS_COUNT  = 2;
    localparam int CDB_ADDR_WIDTH = 8;

    // Select address meaning "nobody owns this bus"; no unit answers to it.
    localparam logic [CDB_ADDR_WIDTH-1:0] CDB_IDLE_ADDR = 8'hFF;

    typedef logic [CDB_BUS_COUNT-1:0][CDB_ADDR_WIDTH-1:0] cdb_select_t;

    // Advance a unit index by one, wrapping from n-1 back to 0.
    function automatic int cdb_wrap_inc(input int idx, input int n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage

// File: rtl/cdb_select_scheduler_rr_first_set.sv
// Combinational find-first-set starting at a given index and wrapping at N-1.
// The search start must lie in 0..N-1.
module cdb_select_scheduler_rr_first_set #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     i_vec,
    input  logic [PTR_W-1:0] i_start,
    output logic             o_found,
    output logic [PTR_W-1:0] o_index
);

    // Walk the vector from the start index; the first set bit met wins.
    always_comb begin
        int j;
        o_found = 1'b0;
        o_index = '0;
        j       = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(i_start) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!o_found && i_vec[j[PTR_W-1:0]]) begin
                o_found = 1'b1;
                o_index = j[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/cdb_select_scheduler.sv
// Round-robin owner of the two common data buses. Picks up to two distinct
// requesting units per cycle, honours per-bus ROB stalls and drives the
// registered select address for each bus (all-ones = idle).
// Optional feature: define CDB_SCHED_WAIT_STATS_EN to add per-unit wait
// counters and the o_max_wait port.
module cdb_select_scheduler
    import cdb_select_scheduler_pkg::*;
#(
    parameter int NUM_UNITS  = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_UNITS-1:0]                       i_req,
    input  logic [CDB_BUS_COUNT-1:0]                   i_stall,
    output logic [CDB_BUS_COUNT-1:0][ADDR_WIDTH-1:0]   o_select,
`ifdef CDB_SCHED_WAIT_STATS_EN
    output logic [CDB_BUS_COUNT-1:0]                   o_valid,
    output logic [15:0]                                o_max_wait
`else
    output logic [CDB_BUS_COUNT-1:0]                   o_valid
`endif
);

    localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam logic [ADDR_WIDTH-1:0] IDLE_SEL = '1;

    logic [CDB_BUS_COUNT-1:0][ADDR_WIDTH-1:0] sel_q, sel_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_UNITS-1:0] mask_q, mask_d;
    logic [NUM_UNITS-1:0] grant_d;

    logic [NUM_UNITS-1:0] eligible;
    logic [NUM_UNITS-1:0] eligible_second;
    logic                 found0, found1;
    logic [PTR_W-1:0]     idx0, idx1;
    logic [PTR_W-1:0]     start1;

    // Units granted last cycle are masked so their stale request is not regranted.
    always_comb begin
        eligible        = i_req & ~mask_q;
        eligible_second = eligible;
        if (found0) begin
            eligible_second[idx0] = 1'b0;
        end
        start1 = PTR_W'(cdb_wrap_inc(int'(idx0), NUM_UNITS));
    end

    cdb_select_scheduler_rr_first_set #(
        .N     (NUM_UNITS),
        .PTR_W (PTR_W)
    ) u_pick0 (
        .i_vec   (eligible),
        .i_start (rr_ptr_q),
        .o_found (found0),
        .o_index (idx0)
    );

    cdb_select_scheduler_rr_first_set #(
        .N     (NUM_UNITS),
        .PTR_W (PTR_W)
    ) u_pick1 (
        .i_vec   (eligible_second),
        .i_start (start1),
        .o_found (found1),
        .o_index (idx1)
    );

    // Map the two picks onto the non-stalled buses and work out pointer/mask.
    always_comb begin
        sel_d    = {CDB_BUS_COUNT{IDLE_SEL}};
        grant_d  = '0;
        rr_ptr_d = rr_ptr_q;
        mask_d   = '0;
        case (i_stall)
            2'b00: begin
                if (found0) begin
                    sel_d[0]      = ADDR_WIDTH'(idx0);
                    grant_d[idx0] = 1'b1;
                    rr_ptr_d      = start1;
                end
                if (found1) begin
                    sel_d[1]      = ADDR_WIDTH'(idx1);
                    grant_d[idx1] = 1'b1;
                    rr_ptr_d      = PTR_W'(cdb_wrap_inc(int'(idx1), NUM_UNITS));
                end
                mask_d = grant_d;
            end
            2'b01: begin
                if (found0) begin
                    sel_d[1]      = ADDR_WIDTH'(idx0);
                    grant_d[idx0] = 1'b1;
                    rr_ptr_d      = start1;
                end
                mask_d = grant_d;
            end
            2'b10: begin
                if (found0) begin
                    sel_d[0]      = ADDR_WIDTH'(idx0);
                    grant_d[idx0] = 1'b1;
                    rr_ptr_d      = start1;
                end
                mask_d = grant_d;
            end
            default: begin
                mask_d = mask_q;
            end
        endcase
    end

    // Scheduler state register; reset drops any in-flight grant immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q    <= {CDB_BUS_COUNT{IDLE_SEL}};
            rr_ptr_q <= '0;
            mask_q   <= '0;
        end else begin
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            mask_q   <= mask_d;
        end
    end

    // A bus is valid exactly when its registered select is not the idle address.
    always_comb begin
        o_select = sel_q;
        for (int b = 0; b < CDB_BUS_COUNT; b++) begin
            o_valid[b] = (sel_q[b] != IDLE_SEL);
        end
    end

`ifdef CDB_SCHED_WAIT_STATS_EN
    logic [15:0] wait_cnt_q [NUM_UNITS];
    logic [15:0] wait_cnt_d [NUM_UNITS];
    logic [15:0] max_wait_q, max_wait_d;

    // Saturating per-unit wait counters and the maximum over them.
    always_comb begin
        max_wait_d = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (!i_req[k] || grant_d[k]) begin
                wait_cnt_d[k] = '0;
            end else if (wait_cnt_q[k] != 16'hFFFF) begin
                wait_cnt_d[k] = wait_cnt_q[k] + 16'd1;
            end else begin
                wait_cnt_d[k] = wait_cnt_q[k];
            end
            if (wait_cnt_q[k] > max_wait_d) begin
                max_wait_d = wait_cnt_q[k];
            end
        end
    end

    // Wait statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                wait_cnt_q[k] <= '0;
            end
            max_wait_q <= '0;
        end else begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                wait_cnt_q[k] <= wait_cnt_d[k];
            end
            max_wait_q <= max_wait_d;
        end
    end

    assign o_max_wait = max_wait_q;
`endif

endmodule
